// File: rtl/recon_row_writer.sv
// rtl/recon_row_writer.sv - decoder-side row writer and JPEG-LS causal context generator
module recon_row_writer #(
    parameter int pixel_length = 8,
    parameter int ROW_WIDTH    = 135,
    parameter int NUM_ROWS     = 311,
    parameter int COL_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [pixel_length-1:0] x_in,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [pixel_length-1:0] prevPixelIn,
    output logic [pixel_length-1:0] a,
    output logic [pixel_length-1:0] b,
    output logic [pixel_length-1:0] c,
    output logic [pixel_length-1:0] d,
    output logic                    ctx_valid,
    output logic                    write_MEM_ONE,
    output logic                    write_MEM_TWO,
    output logic [COL_W-1:0]        col_index,
    output logic [pixel_length-1:0] wr_data,
    output logic                    read_PREV_MEM_ONE,
    output logic                    read_PREV_MEM_TWO,
    output logic [COL_W-1:0]        prev_col_index,
    output logic                    EOL,
    output logic                    EOF,
    output logic                    done
);

    localparam int ROW_W = $clog2(NUM_ROWS + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W:0]   ROW_LEN  = (COL_W + 1)'(ROW_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_B,
        S_CAP_B,
        S_CAP_D,
        S_CTX,
        S_WAIT_X,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state_q, state_nxt;
    logic [ROW_W-1:0]        row_q, row_nxt;
    logic [COL_W-1:0]        col_q, col_nxt;
    logic [pixel_length-1:0] a_q, a_nxt;
    logic [pixel_length-1:0] b_q, b_nxt;
    logic [pixel_length-1:0] c_q, c_nxt;
    logic [pixel_length-1:0] d_q, d_nxt;
    logic [pixel_length-1:0] saved_b0_q, saved_b0_nxt;

    // Even rows live in MEM_ONE, odd rows in MEM_TWO; the previous row is the other one
    logic            row_even;
    logic            first_row;
    logic [COL_W:0]  col_plus2;
    logic            ahead_in_row;
    logic            do_write;
    logic            do_read;

    assign row_even     = ~row_q[0];
    assign first_row    = (row_q == '0);
    assign col_plus2    = {1'b0, col_q} + (COL_W + 1)'(2);
    // A lookahead read for d exists only when a previous row exists and col+2 is inside it
    assign ahead_in_row = !first_row && (col_plus2 < ROW_LEN);

    // State and context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            saved_b0_q <= '0;
        end else begin
            state_q    <= state_nxt;
            row_q      <= row_nxt;
            col_q      <= col_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            c_q        <= c_nxt;
            d_q        <= d_nxt;
            saved_b0_q <= saved_b0_nxt;
        end
    end

    // Next-state, context update and strobe generation
    always_comb begin
        state_nxt      = state_q;
        row_nxt        = row_q;
        col_nxt        = col_q;
        a_nxt          = a_q;
        b_nxt          = b_q;
        c_nxt          = c_q;
        d_nxt          = d_q;
        saved_b0_nxt   = saved_b0_q;
        do_write       = 1'b0;
        do_read        = 1'b0;
        prev_col_index = '0;
        wr_data        = '0;
        ctx_valid      = 1'b0;
        x_ready        = 1'b0;
        EOL            = 1'b0;
        EOF            = 1'b0;
        done           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PRE_B;
                end
            end

            S_PRE_B: begin
                if (first_row) begin
                    // No previous row: the whole upper context is zero
                    b_nxt     = '0;
                    d_nxt     = '0;
                    state_nxt = S_CTX;
                end else begin
                    do_read        = 1'b1;
                    prev_col_index = '0;
                    state_nxt      = S_CAP_B;
                end
            end

            S_CAP_B: begin
                b_nxt = prevPixelIn;
                if (ROW_WIDTH > 1) begin
                    do_read        = 1'b1;
                    prev_col_index = COL_W'(1);
                    state_nxt      = S_CAP_D;
                end else begin
                    // Single-column rows: d mirrors b
                    d_nxt     = prevPixelIn;
                    state_nxt = S_CTX;
                end
            end

            S_CAP_D: begin
                d_nxt     = prevPixelIn;
                state_nxt = S_CTX;
            end

            S_CTX: begin
                // Column 0: a takes b, c takes b of column 0 one row up
                a_nxt        = b_q;
                c_nxt        = saved_b0_q;
                saved_b0_nxt = b_q;
                state_nxt    = S_WAIT_X;
            end

            S_WAIT_X: begin
                ctx_valid = 1'b1;
                x_ready   = 1'b1;
                if (x_valid) begin
                    do_write = 1'b1;
                    wr_data  = x_in;
                    a_nxt    = x_in;
                    c_nxt    = b_q;
                    b_nxt    = d_q;
                    if (col_q == LAST_COL) begin
                        EOL     = 1'b1;
                        col_nxt = '0;
                        row_nxt = row_q + ROW_W'(1);
                        if (row_q == LAST_ROW) begin
                            EOF       = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_PRE_B;
                        end
                    end else begin
                        if (ahead_in_row) begin
                            do_read        = 1'b1;
                            prev_col_index = col_plus2[COL_W-1:0];
                        end else begin
                            // Past the right edge (or row 0): d repeats the new b
                            d_nxt = d_q;
                        end
                        state_nxt = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                // row/col are unchanged since the handshake, so the read decision is recomputed here
                if (ahead_in_row) begin
                    d_nxt = prevPixelIn;
                end
                col_nxt   = col_q + COL_W'(1);
                state_nxt = S_WAIT_X;
            end

            S_DONE: begin
                done = 1'b1;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign write_MEM_ONE     = do_write & row_even;
    assign write_MEM_TWO     = do_write & ~row_even;
    assign read_PREV_MEM_ONE = do_read & ~row_even;
    assign read_PREV_MEM_TWO = do_read & row_even;
    assign col_index         = col_q;
    assign a                 = a_q;
    assign b                 = b_q;
    assign c                 = c_q;
    assign d                 = d_q;

endmodule

// File: tb/tb_recon_row_writer.sv
// tb/tb_recon_row_writer.sv - directed and frame-level checks for recon_row_writer
module tb_recon_row_writer;

    localparam int BW = 135;
    localparam int BR = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    // small instance: 4 x 3 frame
    logic       s_start = 1'b0, s_xv = 1'b0;
    logic [7:0] s_x = '0, s_prev = '0;
    logic [7:0] s_a, s_b, s_c, s_d, s_wd, s_col, s_pcol;
    logic       s_xr, s_cv, s_w1, s_w2, s_r1, s_r2, s_eol, s_eof, s_done;
    logic [7:0] s_m1 [0:255];
    logic [7:0] s_m2 [0:255];

    // large instance: full row width, short frame
    logic       b_start = 1'b0, b_xv = 1'b0;
    logic [7:0] b_x = '0, b_prev = '0;
    logic [7:0] b_a, b_b, b_c, b_d, b_wd, b_col, b_pcol;
    logic       b_xr, b_cv, b_w1, b_w2, b_r1, b_r2, b_eol, b_eof, b_done;
    logic [7:0] b_m1 [0:255];
    logic [7:0] b_m2 [0:255];
    int         b_eol_cnt = 0, b_eof_cnt = 0, conflicts = 0;

    logic [7:0] g_prev [0:BW-1];
    logic [7:0] g_cur  [0:BW-1];
    logic [7:0] g_pp0;

    always #5 clk = ~clk;

    recon_row_writer #(.pixel_length(8), .ROW_WIDTH(4), .NUM_ROWS(3), .COL_W(8)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .x_in(s_x), .x_valid(s_xv), .x_ready(s_xr),
        .prevPixelIn(s_prev), .a(s_a), .b(s_b), .c(s_c), .d(s_d), .ctx_valid(s_cv),
        .write_MEM_ONE(s_w1), .write_MEM_TWO(s_w2), .col_index(s_col), .wr_data(s_wd),
        .read_PREV_MEM_ONE(s_r1), .read_PREV_MEM_TWO(s_r2), .prev_col_index(s_pcol),
        .EOL(s_eol), .EOF(s_eof), .done(s_done)
    );

    recon_row_writer #(.pixel_length(8), .ROW_WIDTH(BW), .NUM_ROWS(BR), .COL_W(8)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .x_in(b_x), .x_valid(b_xv), .x_ready(b_xr),
        .prevPixelIn(b_prev), .a(b_a), .b(b_b), .c(b_c), .d(b_d), .ctx_valid(b_cv),
        .write_MEM_ONE(b_w1), .write_MEM_TWO(b_w2), .col_index(b_col), .wr_data(b_wd),
        .read_PREV_MEM_ONE(b_r1), .read_PREV_MEM_TWO(b_r2), .prev_col_index(b_pcol),
        .EOL(b_eol), .EOF(b_eof), .done(b_done)
    );

    // Row-buffer models with one-cycle read latency, plus pulse and conflict monitors
    always @(posedge clk) begin
        if (s_w1) s_m1[s_col] <= s_wd;
        if (s_w2) s_m2[s_col] <= s_wd;
        if (s_r1) s_prev <= s_m1[s_pcol];
        else if (s_r2) s_prev <= s_m2[s_pcol];
        if (b_w1) b_m1[b_col] <= b_wd;
        if (b_w2) b_m2[b_col] <= b_wd;
        if (b_r1) b_prev <= b_m1[b_pcol];
        else if (b_r2) b_prev <= b_m2[b_pcol];
        if (b_eol) b_eol_cnt <= b_eol_cnt + 1;
        if (b_eof) b_eof_cnt <= b_eof_cnt + 1;
        if ((s_w1 && s_r1) || (s_w2 && s_r2) || (b_w1 && b_r1) || (b_w2 && b_r2))
            conflicts <= conflicts + 1;
    end

    // Run-time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctx4(input logic [7:0] ea, eb, ec, ed);
        return {ea, eb, ec, ed};
    endfunction

    function automatic logic [127:0] s_all();
        return 128'({s_a, s_b, s_c, s_d, s_cv, s_xr, s_w1, s_w2, s_col, s_wd,
                     s_r1, s_r2, s_pcol, s_eol, s_eof, s_done});
    endfunction

    task automatic wait_rdy_s();
        int n = 0;
        while (!s_xr && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_timeout", 128'(s_xr), 128'(1'b1));
    endtask

    task automatic wait_rdy_b();
        int n = 0;
        while (!b_xr && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_timeout", 128'(b_xr), 128'(1'b1));
    endtask

    task automatic feed_s(input logic [7:0] v, input logic [31:0] ctx, input logic [7:0] col,
                          input logic mem1, input logic eol, input logic eof);
        wait_rdy_s();
        check("s_ctx", 128'({s_a, s_b, s_c, s_d}), 128'(ctx));
        s_x  = v;
        s_xv = 1'b1;
        #1;
        check("s_write", 128'({s_w1, s_w2, s_col, s_wd, s_eol, s_eof}),
              128'({mem1, ~mem1, col, v, eol, eof}));
        @(negedge clk);
        s_xv = 1'b0;
    endtask

    initial begin
        logic [7:0] ea, eb, ec, ed, v;
        repeat (3) @(negedge clk);
        check("reset_outputs", s_all(), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;

        // row 0 into MEM_ONE
        feed_s(8'd10, ctx4(0, 0, 0, 0), 8'd0, 1'b1, 1'b0, 1'b0);
        feed_s(8'd20, ctx4(10, 0, 0, 0), 8'd1, 1'b1, 1'b0, 1'b0);
        feed_s(8'd30, ctx4(20, 0, 0, 0), 8'd2, 1'b1, 1'b0, 1'b0);
        feed_s(8'd40, ctx4(30, 0, 0, 0), 8'd3, 1'b1, 1'b1, 1'b0);

        // stall at row 1 col 0
        wait_rdy_s();
        repeat (5) begin
            check("stall", 128'({s_cv, s_w1, s_w2, s_a, s_b, s_c, s_d}),
                  128'({1'b1, 2'b00, ctx4(10, 10, 0, 20)}));
            @(negedge clk);
        end

        // row 1 into MEM_TWO
        feed_s(8'd11, ctx4(10, 10, 0, 20), 8'd0, 1'b0, 1'b0, 1'b0);
        feed_s(8'd21, ctx4(11, 20, 10, 30), 8'd1, 1'b0, 1'b0, 1'b0);
        feed_s(8'd31, ctx4(21, 30, 20, 40), 8'd2, 1'b0, 1'b0, 1'b0);
        feed_s(8'd41, ctx4(31, 40, 30, 40), 8'd3, 1'b0, 1'b1, 1'b0);

        // row 2 into MEM_ONE, last row
        feed_s(8'd12, ctx4(11, 11, 10, 21), 8'd0, 1'b1, 1'b0, 1'b0);
        feed_s(8'd22, ctx4(12, 21, 11, 31), 8'd1, 1'b1, 1'b0, 1'b0);
        feed_s(8'd32, ctx4(22, 31, 21, 41), 8'd2, 1'b1, 1'b0, 1'b0);
        feed_s(8'd42, ctx4(32, 41, 31, 41), 8'd3, 1'b1, 1'b1, 1'b1);
        check("done_state", 128'({s_done, s_xr, s_cv, s_eol, s_eof, s_w1, s_w2}), 128'(7'b1000000));

        // start is ignored in DONE
        s_start = 1'b1;
        repeat (3) @(negedge clk);
        s_start = 1'b0;
        check("done_sticky", 128'({s_done, s_xr, s_r1, s_r2}), 128'(4'b1000));

        // reset mid-frame at row 1 col 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        feed_s(8'd10, ctx4(0, 0, 0, 0), 8'd0, 1'b1, 1'b0, 1'b0);
        feed_s(8'd20, ctx4(10, 0, 0, 0), 8'd1, 1'b1, 1'b0, 1'b0);
        feed_s(8'd30, ctx4(20, 0, 0, 0), 8'd2, 1'b1, 1'b0, 1'b0);
        feed_s(8'd40, ctx4(30, 0, 0, 0), 8'd3, 1'b1, 1'b1, 1'b0);
        feed_s(8'd11, ctx4(10, 10, 0, 20), 8'd0, 1'b0, 1'b0, 1'b0);
        feed_s(8'd21, ctx4(11, 20, 10, 30), 8'd1, 1'b0, 1'b0, 1'b0);
        wait_rdy_s();
        check("pre_reset_ctx", 128'({s_a, s_b, s_c, s_d}), 128'(ctx4(21, 30, 20, 40)));
        reset = 1'b1;
        s_x   = 8'd99;
        s_xv  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midframe_reset", s_all(), 128'(0));
        @(negedge clk);
        check("idle_ignores_x", s_all(), 128'(0));
        s_xv = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        feed_s(8'd5, ctx4(0, 0, 0, 0), 8'd0, 1'b1, 1'b0, 1'b0);

        // full-width frame with random pixels against a context model
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        g_pp0 = '0;
        for (int r = 0; r < BR; r++) begin
            for (int c = 0; c < BW; c++) begin
                if (r == 0) begin
                    ea = (c == 0) ? 8'd0 : g_cur[c-1];
                    eb = 8'd0;
                    ec = 8'd0;
                    ed = 8'd0;
                end else begin
                    ea = (c == 0) ? g_prev[0] : g_cur[c-1];
                    eb = g_prev[c];
                    ec = (c == 0) ? ((r >= 2) ? g_pp0 : 8'd0) : g_prev[c-1];
                    ed = (c + 1 < BW) ? g_prev[c+1] : g_prev[c];
                end
                v = 8'($urandom_range(0, 255));
                wait_rdy_b();
                check("b_ctx", 128'({b_a, b_b, b_c, b_d}), 128'(ctx4(ea, eb, ec, ed)));
                b_x  = v;
                b_xv = 1'b1;
                #1;
                check("b_write", 128'({b_w1, b_w2, b_col, b_wd, b_eol, b_eof}),
                      128'({~r[0], r[0], 8'(c), v, (c == BW - 1), (c == BW - 1) && (r == BR - 1)}));
                g_cur[c] = v;
                @(negedge clk);
                b_xv = 1'b0;
            end
            g_pp0 = g_prev[0];
            for (int c = 0; c < BW; c++) g_prev[c] = g_cur[c];
        end
        @(negedge clk);
        check("b_eol_count", 128'(b_eol_cnt), 128'(BR));
        check("b_eof_count", 128'(b_eof_cnt), 128'(1));
        check("b_done", 128'({b_done, b_xr}), 128'(2'b10));
        check("strobe_conflicts", 128'(conflicts), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
